// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 Set-2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   // Keyboard status/acknowledge bytes that never represent a key.
   localparam logic [7:0] PS2_IGN_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_IGN_ACK    = 8'hFA;
   localparam logic [7:0] PS2_IGN_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_IGN_RESEND = 8'hFE;
   localparam logic [7:0] PS2_IGN_BAT_ER = 8'hFC;
   localparam logic [7:0] PS2_IGN_OVR0   = 8'h00;
   localparam logic [7:0] PS2_IGN_OVR1   = 8'hFF;

   localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

   function automatic logic is_ignored(input logic [7:0] b);
      return (b == PS2_IGN_BAT_OK) || (b == PS2_IGN_ACK)    ||
             (b == PS2_IGN_ECHO)   || (b == PS2_IGN_RESEND) ||
             (b == PS2_IGN_BAT_ER) || (b == PS2_IGN_OVR0)   ||
             (b == PS2_IGN_OVR1);
   endfunction

   function automatic logic is_fake_shift(input logic [7:0] b);
      return (b == PS2_FAKE_LSHIFT) || (b == PS2_FAKE_RSHIFT);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises a raw PS/2 line, rejects glitches shorter than FILTER_LEN
// samples, and pulses fall for one cycle when the filtered level drops.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic line_raw,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          line_meta;
   logic          line_sync;
   logic          level_q;
   logic [CW-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, like real hardware.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         line_meta <= 1'b1;
         line_sync <= 1'b1;
         level_q   <= 1'b1;
         cnt_q     <= '0;
         fall      <= 1'b0;
      end else begin
         line_meta <= line_raw;
         line_sync <= line_meta;
         fall      <= 1'b0;
         if (line_sync == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            // FILTER_LEN consecutive differing samples: accept the new level.
            level_q <= line_sync;
            cnt_q   <= '0;
            fall    <= level_q;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 Set-2 receiver: frames bits off the keyboard lines and decodes
// E0/F0/E1 prefixes into single-cycle key events for the keyboard matrix.
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 48000,
   parameter int PAUSE_SKIP  = 7
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_strobe,
   output logic       key_pressed,
   output logic       key_extended,
   output logic [7:0] key_code,
   output logic       frame_err
);

   localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);

   logic rst_meta;
   logic rst_n;

   // Asserts immediately, releases two clocks after reset_n rises.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   logic clk_fall;

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_clk_filter (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .line_raw (ps2_clk),
      .fall     (clk_fall)
   );

   logic data_meta;
   logic data_sync;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         data_meta <= ps2_data;
         data_sync <= data_meta;
      end
   end

   state_t           state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic [TMO_W-1:0] tmo_q;
   logic             byte_ok;
   logic             byte_bad;
   logic             tmo_hit;

   // NOTE: every signal driven here gets a default first, so no path
   // through the block can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      byte_ok   = 1'b0;
      byte_bad  = 1'b0;
      tmo_hit   = 1'b0;
      if (clk_fall) begin
         unique case (state_q)
            IDLE: begin
               if (!data_sync) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d   = {data_sync, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = data_sync;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (data_sync && (^{shift_q, par_q})) byte_ok  = 1'b1;
               else                                  byte_bad = 1'b1;
            end
         endcase
      end else if (state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYC)) begin
         // An edge in the same cycle takes the branch above instead.
         tmo_hit = 1'b1;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         if (clk_fall || state_q == IDLE)       tmo_q <= '0;
         else if (tmo_q != TMO_W'(TIMEOUT_CYC)) tmo_q <= tmo_q + TMO_W'(1);
      end
   end

   logic              ext_q;
   logic              brk_q;
   logic [SKIP_W-1:0] skip_q;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         skip_q       <= '0;
         key_strobe   <= 1'b0;
         key_pressed  <= 1'b0;
         key_extended <= 1'b0;
         key_code     <= '0;
         frame_err    <= 1'b0;
      end else begin
         key_strobe <= 1'b0;
         frame_err  <= tmo_hit | byte_bad;
         if (tmo_hit || byte_bad) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end else if (byte_ok) begin
            if (skip_q != '0) begin
               skip_q <= skip_q - SKIP_W'(1);
            end else if (shift_q == PS2_EXT) begin
               ext_q <= 1'b1;
            end else if (shift_q == PS2_BRK) begin
               brk_q <= 1'b1;
            end else if (shift_q == PS2_PAUSE) begin
               skip_q <= SKIP_W'(PAUSE_SKIP);
               ext_q  <= 1'b0;
               brk_q  <= 1'b0;
            end else if (is_ignored(shift_q) || (ext_q && is_fake_shift(shift_q))) begin
               ext_q <= 1'b0;
               brk_q <= 1'b0;
            end else begin
               key_strobe   <= 1'b1;
               key_code     <= shift_q;
               key_pressed  <= ~brk_q;
               key_extended <= ext_q;
               ext_q        <= 1'b0;
               brk_q        <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Receives raw PS/2 keyboard clock/data lines and decodes Set-2 frames into single-cycle key events.
- Outputs key_strobe/key_pressed/key_extended/key_code in exactly the form the Oric keyboard matrix block consumes.
- Sits directly upstream of the matrix block.
- Handles line synchronisation, glitch filtering, frame and parity checking, timeout recovery, and E0/F0/E1 prefix decoding.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples of ps2_clk needed before the filtered level changes.
- TIMEOUT_CYC, 48000: clk_sys cycles without a falling edge that abort a partial frame (2 ms at 24 MHz).
- PAUSE_SKIP, 7: bytes discarded after an E1 prefix.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- key_strobe  out  1  one-cycle pulse, event valid
- key_pressed  out  1  1 = make, 0 = break
- key_extended  out  1  event was E0-prefixed
- key_code  out  8  scan code byte
- frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n=0, all outputs are 0, the FSM is IDLE, prefix flags are clear, the skip counter is 0, and the filtered clock level is 1. Deassertion is synchronised internally.
- Line conditioning:
  - ps2_clk and ps2_data pass through 2-FF synchronisers.
  - The filtered clock level changes only after FILTER_LEN equal consecutive samples; shorter glitches are ignored.
  - A falling edge is the filtered level going 1->0. The data bit is sampled from synchronised ps2_data in that same cycle.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: shift 8 bits in LSB first; after the 8th, go to PARITY.
  - PARITY: capture the bit; odd parity over data+parity must hold.
  - STOP: the bit must be 1. On a good frame, pass the byte to the decoder. On bad parity or stop=0, discard the byte, pulse frame_err, clear prefix flags, and go to IDLE.
- Timeout:
  - The counter resets on every falling edge and whenever the FSM is in IDLE.
  - Reaching TIMEOUT_CYC in any non-IDLE state goes to IDLE, pulses frame_err, and clears prefix flags.
  - Counter width is clog2(TIMEOUT_CYC+1); it saturates and never wraps.
- Decoder, per good byte b:
  - Skip counter nonzero: decrement it; no event.
  - b=E0: set ext. b=F0: set brk. b=E1: skip counter = PAUSE_SKIP, clear flags.
  - b in {AA, FA, EE, FE, FC, 00, FF}: drop and clear flags.
  - ext=1 and b in {12, 59} (fake shifts): drop and clear flags.
  - Otherwise emit: key_code=b, key_pressed=~brk, key_extended=ext, then clear both flags.
- Latency and output timing:
  - key_strobe rises in the cycle after the stop-bit falling edge and lasts exactly 1 cycle.
  - key_code/key_pressed/key_extended are registered with the strobe and hold until the next event.
- Simultaneous events:
  - A timeout and a falling edge in the same cycle: the edge wins and the counter resets.
  - Strobe and frame_err never coincide.
  - Asynchronous reset mid-frame discards the partial frame and all prefix state.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - prefix constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1;
  - ignored-code constants;
  - fake-shift constants 8'h12 and 8'h59.
- Sub-module ps2_line_filter covers the synchroniser, the FILTER_LEN glitch filter and the falling-edge pulse. It is instantiated for ps2_clk; ps2_data uses a bare 2-FF synchroniser.

Test Plan:
- Frames 1C, then F0 1C -> strobe with code=1C, pressed=1, ext=0; then strobe with code=1C, pressed=0, ext=0; strobe each exactly 1 cycle, 1 cycle after the stop edge.
- E0 75, then E0 F0 75 -> code=75, ext=1, pressed=1; then code=75, ext=1, pressed=0; no strobe on any prefix byte.
- 1C sent with wrong parity -> no strobe, one frame_err pulse; following good 1C -> normal make event.
- E0, then 5 bits of a frame, then idle for TIMEOUT_CYC+10 cycles -> frame_err, FSM IDLE; next 6B frame -> ext=0, code=6B.
- 3-cycle low glitch on ps2_clk during IDLE and mid-DATA -> no bit sampled; frame decodes correctly. Pause sequence E1 14 77 E1 F0 14 F0 77 -> zero strobes; following 29 -> space make.
- E0 12 E0 75 -> a single strobe with code=75, ext=1; no code-12 event. Reset_n pulsed mid-frame after F0 -> next 1C reports pressed=1.
